// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// stream_mux_pkg : mode encodings and round-robin pointer helper shared by
//                  the stream_mux_arb family.   Rev 1.0
// ============================================================================
package stream_mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Pointer moves to the channel after the winner, wrapping at n-1.
    function automatic int rr_next_ptr(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : pointer-based N-request round-robin search; one-hot grant
//              plus encoded index.   Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [SEL_W-1:0] o_idx,
    output logic             o_any
);

    int w_c;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_c     = 0;
        for (int k = 0; k < N; k++) begin
            w_c = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_idx      = SEL_W'(w_c);
                o_grant[w_c] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// stream_mux_arb : N:1 valid/ready stream mux, explicit select or round-robin,
//                  registered output. Packet lock with STREAM_MUX_ARB_PKT_LOCK_EN.
//                  Rev 1.0
// ============================================================================
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MODE,
    input  logic [SEL_W-1:0]     SEL,
    input  logic [N*WIDTH-1:0]   IN_DATA,
    input  logic [N-1:0]         IN_VALID,
    output logic [N-1:0]         IN_READY,
`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
    input  logic [N-1:0]         IN_LAST,
`endif
    output logic [WIDTH-1:0]     OUT_DATA,
    output logic [SEL_W-1:0]     OUT_CH,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY
);

    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [N-1:0]     w_rr_grant;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;

    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_idx;
    logic             w_any;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_last;
    logic             w_locked;
    logic [SEL_W-1:0] w_lock_ch;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr (
        .i_req   (IN_VALID),
        .i_ptr   (r_ptr),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_any   (w_rr_any)
    );

`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
    logic             r_locked;
    logic [SEL_W-1:0] r_lock_ch;

    assign w_locked  = r_locked;
    assign w_lock_ch = r_lock_ch;
    assign w_last    = IN_LAST[w_idx];

    // A non-LAST beat pins the grant to its channel until the LAST beat moves.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            r_locked  <= ~w_last;
            r_lock_ch <= w_idx;
        end
    end
`else
    assign w_locked  = 1'b0;
    assign w_lock_ch = '0;
    assign w_last    = 1'b1;
`endif

    always_comb begin
        w_idx = '0;
        w_any = 1'b0;
        if (w_locked) begin
            w_idx = w_lock_ch;
            w_any = IN_VALID[w_lock_ch];
        end else if (MODE == MODE_RR) begin
            w_idx = w_rr_idx;
            w_any = w_rr_any;
        end else if (int'(SEL) < N) begin
            w_idx = SEL;
            w_any = IN_VALID[SEL];
        end
        w_grant = '0;
        if (w_any) begin
            w_grant[w_idx] = 1'b1;
        end
    end

    assign w_load_en = ~r_valid | OUT_READY;
    assign w_xfer    = w_any & w_load_en & ~RST;
    assign IN_READY  = w_grant & {N{w_load_en & ~RST}};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= IN_DATA[w_idx*WIDTH +: WIDTH];
            r_ch    <= w_idx;
            r_valid <= 1'b1;
            if (MODE == MODE_RR && w_last) begin
                r_ptr <= SEL_W'(rr_next_ptr(int'(w_idx), N));
            end
        end else if (OUT_READY) begin
            r_valid <= 1'b0;
        end
    end

    assign OUT_DATA  = r_data;
    assign OUT_CH    = r_ch;
    assign OUT_VALID = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_arb.sv
`default_nettype none
// ============================================================================
// tb_stream_mux_arb : directed and random stimulus against a behavioural
//                     model of the stream mux.   Rev 1.0
// ============================================================================
module tb_stream_mux_arb;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [1:0]     sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N-1:0]   in_last;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3;

    int total = 0;
    int bad   = 0;

    bit         m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;
    bit         m_lock;
    int         m_lock_ch;
    bit         lock_en;

    always #5 clk = ~clk;

    stream_mux_arb #(.WIDTH(W), .N(N)) dut (
        .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel),
        .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
        .IN_LAST(in_last),
`endif
        .OUT_DATA(out_data), .OUT_CH(out_ch), .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
    );

    stream_mux_arb #(.WIDTH(W), .N(3)) dut3 (
        .CLK(clk), .RST(rst), .MODE(mode), .SEL(sel),
        .IN_DATA(in_data[3*W-1:0]), .IN_VALID(in_valid[2:0]), .IN_READY(in_ready3),
`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
        .IN_LAST(in_last[2:0]),
`endif
        .OUT_DATA(out_data3), .OUT_CH(out_ch3), .OUT_VALID(out_valid3),
        .OUT_READY(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which channel the rules grant right now, or -1.
    function automatic int exp_grant();
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b0) begin
            if (int'(sel) < N && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Inputs already applied: check ready, cross one edge, update model, check outputs.
    task automatic step(input string tag);
        int         g;
        bit         xfer;
        bit         last;
        logic [3:0] er;
        #1;
        g    = exp_grant();
        xfer = (g >= 0) && (!m_valid || out_ready) && !rst;
        er   = xfer ? (4'b0001 << g) : 4'b0000;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
        last = lock_en ? in_last[(g < 0) ? 0 : g] : 1'b1;
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = 8'h00; m_ch = 0; m_ptr = 0; m_lock = 0;
        end else if (xfer) begin
            m_data  = in_data[g*W +: W];
            m_ch    = g;
            m_valid = 1;
            if (mode && last) m_ptr = (g + 1) % N;
            m_lock    = !last;
            m_lock_ch = g;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"},  32'(out_data),  32'(m_data));
        chk({tag, ".out_ch"},    32'(out_ch),    32'(m_ch));
    endtask

    task automatic set_rr_data();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'h10 + 8'(i);
    endtask

    initial begin
`ifdef STREAM_MUX_ARB_PKT_LOCK_EN
        lock_en = 1;
`else
        lock_en = 0;
`endif
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0; m_lock = 0; m_lock_ch = 0;
        rst = 1; mode = 0; sel = 0; in_data = '0; in_valid = '0;
        in_last = '1; out_ready = 1;
        step("reset0");
        step("reset1");
        chk("reset.out_valid", 32'(out_valid), 0);
        rst = 0;

        // Explicit select of channel 2.
        mode = 0; sel = 2; in_valid = 4'b0101; in_data = 32'h003C_0000 | 32'h0000_0011;
        step("sel2");
        chk("sel2.data", 32'(out_data), 32'h3C);
        chk("sel2.ch", 32'(out_ch), 2);
        in_valid = 4'b0011;
        step("sel2_invalid");
        chk("sel2_invalid.drained", 32'(out_valid), 0);

        // SEL beyond the channel count of a 3-channel instance.
        sel = 3; in_valid = 4'b1111;
        #1;
        chk("n3_sel3.in_ready", 32'(in_ready3), 0);
        step("sel3_n4");
        in_valid = 4'b0000;
        step("idle");

        // Round-robin, all channels busy.
        rst = 1; step("rr_rst"); rst = 0;
        mode = 1; in_valid = 4'b1111; set_rr_data();
        for (int i = 0; i < 5; i++) begin
            step("rr");
            chk("rr.ch_seq", 32'(out_ch), 32'(i % N));
            chk("rr.data_seq", 32'(out_data), 32'(8'h10 + 8'(i % N)));
        end

        // Backpressure then release.
        out_ready = 0;
        for (int i = 0; i < 3; i++) step("stall");
        out_ready = 1;
        step("release");
        chk("release.valid", 32'(out_valid), 1);

        // Reset mid-stream with A5 held.
        mode = 0; sel = 0; in_valid = 4'b0001; in_data = 32'h0000_00A5;
        step("load_a5");
        out_ready = 0; in_valid = 4'b0000;
        step("hold_a5");
        chk("hold_a5.data", 32'(out_data), 32'hA5);
        rst = 1;
        step("mid_rst");
        chk("mid_rst.data", 32'(out_data), 0);
        rst = 0; out_ready = 1; mode = 1; in_valid = 4'b1111; set_rr_data();
        step("post_rst");
        chk("post_rst.ch", 32'(out_ch), 0);

        if (lock_en) begin
            // Advance pointer to 1, then ch1 sends a 3-beat packet.
            in_valid = 4'b0000;
            step("lk_idle");
            rst = 1; step("lk_rst"); rst = 0;
            in_valid = 4'b0001; in_last = 4'b1111;
            step("lk_ptr1");
            in_valid = 4'b0111; in_last = 4'b1101;
            step("lk_b0");
            step("lk_b1");
            in_last = 4'b1111;
            step("lk_b2");
            chk("lk_b2.ch", 32'(out_ch), 1);
            step("lk_next");
            chk("lk_next.ch", 32'(out_ch), 2);
            step("lk_next2");
            chk("lk_next2.ch", 32'(out_ch), 0);
        end

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            rst       = ($urandom_range(0, 49) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            in_last   = lock_en ? 4'($urandom) : 4'b1111;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
